// File: rtl/leaf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : leaf_arb_pkg
// Description : Shared types and helpers for the leaf output arbiter.
//               - arb_state_t            : arbiter FSM state encoding
//               - c_default_payload_bits : default beat data width
//               - id_width()             : requester index width (min 1 bit)
// Revision    : 1.0 - initial release
// ============================================================================
package leaf_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int c_default_payload_bits = 32;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : leaf_arb_pkg
`default_nettype wire

// File: rtl/leaf_out_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Returns the first
//               requester with req set after index 'last', wrapping round.
// Ports       : req       - request vector
//               last      - index of the previous grantee
//               grant_oh  - one-hot selected requester (all zero if none)
//               grant_idx - index of the selected requester (0 if none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx
);

  logic            w_found;
  logic [ID_W-1:0] w_idx;

  // Scan starts one past 'last' so the previous grantee is considered last.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(last) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found         = 1'b1;
        grant_oh[w_idx] = 1'b1;
        grant_idx       = w_idx;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/leaf_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : leaf_out_arbiter
// Description : Round-robin arbiter merging NUM_REQ vld/ack user streams into
//               one registered leaf output port. A grant lasts until the
//               grantee drops req_vld or its burst limit is reached; one IDLE
//               cycle separates consecutive grants.
// Config      : LEAF_ARB_BURST_EN - defined: up to BURST_LEN beats per grant;
//               undefined: one beat per grant (beat-by-beat interleave).
// Ports       : clk, reset_n     - clock, asynchronous active-low reset
//               req_din/vld/ack  - per-requester data, valid, accept
//               out_dout/vld/ack - registered output beat and its accept
//               grant_id         - index of current or last grantee
//               busy             - high while a grant is active
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_out_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = c_default_payload_bits,
  parameter int BURST_LEN    = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_din,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [PAYLOAD_BITS-1:0]         out_dout,
  output logic                            out_vld,
  input  logic                            out_ack,
  output logic [id_width(NUM_REQ)-1:0]    grant_id,
  output logic                            busy
);

  localparam int c_id_w  = id_width(NUM_REQ);
  localparam int c_cnt_w = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
`ifdef LEAF_ARB_BURST_EN
  localparam int c_burst = BURST_LEN;
`else
  localparam int c_burst = 1;
`endif
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_burst - 1);
  localparam logic [c_id_w-1:0]  c_last_init = c_id_w'(NUM_REQ - 1);

  arb_state_t               r_state;
  arb_state_t               w_state_nxt;
  logic [c_id_w-1:0]        r_grant_id;
  logic [c_id_w-1:0]        r_last_grant;
  logic [c_cnt_w-1:0]       r_beat_cnt;
  logic [c_id_w-1:0]        w_pick_idx;
  logic [NUM_REQ-1:0]       w_pick_oh;
  logic                     w_pick_vld;
  logic                     w_room;
  logic                     w_accept;
  logic                     w_release;
  logic [PAYLOAD_BITS-1:0]  w_din [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_din[gi] = req_din[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (c_id_w)
  ) u_rr_pick (
    .req       (req_vld),
    .last      (r_last_grant),
    .grant_oh  (w_pick_oh),
    .grant_idx (w_pick_idx)
  );

  assign w_pick_vld = |w_pick_oh;

  // Output register can take a beat if empty or being drained this cycle.
  assign w_room    = !out_vld || out_ack;
  assign w_accept  = (r_state == ST_GRANT) && req_vld[r_grant_id] && w_room;
  // Release either on grantee withdrawal or on acceptance of the final beat.
  assign w_release = (r_state == ST_GRANT) &&
                     (!req_vld[r_grant_id] ||
                      (w_accept && (r_beat_cnt == c_last_beat)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ack     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        req_ack[r_grant_id] = w_room;
        if (w_release) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant_id   <= '0;
      r_last_grant <= c_last_init;
      r_beat_cnt   <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_pick_vld) begin
        r_grant_id <= w_pick_idx;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_release) begin
        r_last_grant <= r_grant_id;
      end
    end
  end

  // A newly accepted beat takes priority over clearing on out_ack, so a beat
  // drained and a beat loaded in the same cycle never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_dout <= '0;
      out_vld  <= 1'b0;
    end else begin
      if (w_accept) begin
        out_dout <= w_din[r_grant_id];
        out_vld  <= 1'b1;
      end else if (out_ack) begin
        out_vld  <= 1'b0;
      end
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state == ST_GRANT);

endmodule : leaf_out_arbiter
`default_nettype wire

// File: tb/tb_leaf_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_leaf_out_arbiter
// Description : Directed self-checking bench for leaf_out_arbiter with
//               NUM_REQ=4, PAYLOAD_BITS=32, BURST_LEN=4. Expected values
//               follow the build: LEAF_ARB_BURST_EN gives 4-beat grants,
//               otherwise one beat per grant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_out_arbiter;

  localparam int NR = 4;
  localparam int PB = 32;
  localparam int BL = 4;
`ifdef LEAF_ARB_BURST_EN
  localparam int B = BL;
`else
  localparam int B = 1;
`endif

  logic              clk;
  logic              reset_n;
  logic [NR*PB-1:0]  req_din;
  logic [NR-1:0]     req_vld;
  logic [NR-1:0]     req_ack;
  logic [PB-1:0]     out_dout;
  logic              out_vld;
  logic              out_ack;
  logic [1:0]        grant_id;
  logic              busy;

  leaf_out_arbiter #(
    .NUM_REQ      (NR),
    .PAYLOAD_BITS (PB),
    .BURST_LEN    (BL)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_din  (req_din),
    .req_vld  (req_vld),
    .req_ack  (req_ack),
    .out_dout (out_dout),
    .out_vld  (out_vld),
    .out_ack  (out_ack),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks;
  int            n_fail;
  int            cyc;
  logic [31:0]   src_q [NR][$];
  logic [31:0]   beat_log [$];
  int            beat_cyc [$];
  int            grant_log [$];
  logic          s_vld;
  logic [31:0]   s_dout;
  logic [NR-1:0] s_ack;
  logic          s_busy;
  logic [1:0]    s_gid;
  logic          prev_busy;

  function automatic logic [31:0] tag(input int r, input int b);
    return {20'hD0000, 4'(r), 8'(b)};
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        req_vld[i]          = 1'b1;
        req_din[i*PB +: PB] = src_q[i][0];
      end else begin
        req_vld[i]          = 1'b0;
        req_din[i*PB +: PB] = '0;
      end
    end
  endtask

  // One clock cycle: sample at the falling edge, then retire accepted beats
  // from the source queues just after the rising edge.
  task automatic tick();
    logic [NR-1:0] acc;
    @(negedge clk);
    s_vld  = out_vld;
    s_dout = out_dout;
    s_ack  = req_ack;
    s_busy = busy;
    s_gid  = grant_id;
    acc    = req_vld & req_ack;
    if (out_vld && out_ack) begin
      beat_log.push_back(out_dout);
      beat_cyc.push_back(cyc);
    end
    if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
    prev_busy = busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
    end
    cyc++;
    drive();
  endtask

  task automatic clear_logs();
    beat_log.delete();
    beat_cyc.delete();
    grant_log.delete();
    cyc       = 0;
    prev_busy = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    out_ack = 1'b1;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
    n_checks++;
    if (out_dout !== 32'h0) begin n_fail++; $display("FAIL reset_out_dout: got %h want 0", out_dout); end
    n_checks++;
    if (req_ack !== 4'b0) begin n_fail++; $display("FAIL reset_req_ack: got %b want 0000", req_ack); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
  endtask

  task automatic test_single();
    logic [7:0]  e_vld;
    logic [7:0]  e_busy;
    logic [31:0] e_dout;
    apply_reset();
    src_q[2].push_back(32'hA1);
    src_q[2].push_back(32'hA2);
    src_q[2].push_back(32'hA3);
    drive();
`ifdef LEAF_ARB_BURST_EN
    e_vld  = 8'b0001_1100;
    e_busy = 8'b0001_1110;
`else
    e_vld  = 8'b0101_0100;
    e_busy = 8'b0010_1010;
`endif
    for (int c = 0; c < 8; c++) begin
      tick();
`ifdef LEAF_ARB_BURST_EN
      e_dout = 32'hA1 + 32'(c - 2);
`else
      e_dout = 32'hA1 + 32'((c - 2) / 2);
`endif
      n_checks++;
      if (s_vld !== e_vld[c]) begin n_fail++; $display("FAIL single_out_vld c%0d: got %b want %b", c, s_vld, e_vld[c]); end
      n_checks++;
      if (s_busy !== e_busy[c]) begin n_fail++; $display("FAIL single_busy c%0d: got %b want %b", c, s_busy, e_busy[c]); end
      if (e_vld[c]) begin
        n_checks++;
        if (s_dout !== e_dout) begin n_fail++; $display("FAIL single_out_dout c%0d: got %h want %h", c, s_dout, e_dout); end
      end
      if (c == 1) begin
        n_checks++;
        if (s_gid !== 2'd2) begin n_fail++; $display("FAIL single_grant_id: got %0d want 2", s_gid); end
        n_checks++;
        if (s_ack !== 4'b0100) begin n_fail++; $display("FAIL single_req_ack: got %b want 0100", s_ack); end
      end
    end
  endtask

  task automatic test_fairness();
    int n;
    int k;
    apply_reset();
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < 8; b++) src_q[r].push_back(tag(r, b));
    drive();
    n = 0;
    while (beat_log.size() < 20 && n < 200) begin
      tick();
      n++;
    end
    n_checks++;
    if (beat_log.size() < 20) begin
      n_fail++;
      $display("FAIL fair_timeout: got %0d beats want 20", beat_log.size());
    end else begin
      for (int j = 0; j < 20; j++) begin
        k = j / B;
        n_checks++;
        if (beat_log[j] !== tag(k % 4, (k / 4) * B + j % B)) begin
          n_fail++;
          $display("FAIL fair_data beat%0d: got %h want %h", j, beat_log[j], tag(k % 4, (k / 4) * B + j % B));
        end
        n_checks++;
        if (beat_cyc[j] !== 2 + k * (B + 1) + j % B) begin
          n_fail++;
          $display("FAIL fair_cycle beat%0d: got %0d want %0d", j, beat_cyc[j], 2 + k * (B + 1) + j % B);
        end
      end
      for (int g = 0; g < 5; g++) begin
        n_checks++;
        if (grant_log[g] !== g % 4) begin n_fail++; $display("FAIL fair_grant %0d: got %0d want %0d", g, grant_log[g], g % 4); end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ack = 1'b0;
    for (int b = 0; b < 6; b++) src_q[1].push_back(tag(1, b));
    drive();
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (s_vld !== 1'b1) begin n_fail++; $display("FAIL bp_out_vld c%0d: got %b want 1", c, s_vld); end
      n_checks++;
      if (s_dout !== tag(1, 0)) begin n_fail++; $display("FAIL bp_out_dout c%0d: got %h want %h", c, s_dout, tag(1, 0)); end
      n_checks++;
      if (s_ack !== 4'b0000) begin n_fail++; $display("FAIL bp_req_ack c%0d: got %b want 0000", c, s_ack); end
    end
    // Irregular out_ack after the stall exercises load-while-draining.
    for (int c = 0; c < 60; c++) begin
      out_ack = (c % 3 != 2);
      tick();
    end
    out_ack = 1'b1;
    n_checks++;
    if (beat_log.size() !== 6) begin
      n_fail++;
      $display("FAIL bp_beat_count: got %0d want 6", beat_log.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        n_checks++;
        if (beat_log[j] !== tag(1, j)) begin n_fail++; $display("FAIL bp_order beat%0d: got %h want %h", j, beat_log[j], tag(1, j)); end
      end
    end
  endtask

  task automatic test_early_release();
    logic [31:0] e_beats [6];
    int          e_grants [6];
    int          n_grants;
    logic [39:0] busy_h;
    logic [1:0]  gid_h [40];
    apply_reset();
    src_q[1].push_back(tag(1, 0));
    src_q[1].push_back(tag(1, 1));
    drive();
    tick();
    for (int b = 0; b < 2; b++) begin
      src_q[0].push_back(tag(0, b));
      src_q[2].push_back(tag(2, b));
    end
    drive();
    busy_h    = '0;
    busy_h[0] = s_busy;
    gid_h[0]  = s_gid;
    for (int c = 1; c < 40; c++) begin
      tick();
      busy_h[c] = s_busy;
      gid_h[c]  = s_gid;
    end
`ifdef LEAF_ARB_BURST_EN
    e_beats  = '{tag(1, 0), tag(1, 1), tag(2, 0), tag(2, 1), tag(0, 0), tag(0, 1)};
    e_grants = '{1, 2, 0, 0, 0, 0};
    n_grants = 3;
    n_checks++;
    if (busy_h[3] !== 1'b1) begin n_fail++; $display("FAIL early_busy_c3: got %b want 1", busy_h[3]); end
    n_checks++;
    if (busy_h[4] !== 1'b0) begin n_fail++; $display("FAIL early_idle_c4: got %b want 0", busy_h[4]); end
    n_checks++;
    if (gid_h[5] !== 2'd2) begin n_fail++; $display("FAIL early_next_grant_c5: got %0d want 2", gid_h[5]); end
`else
    e_beats  = '{tag(1, 0), tag(2, 0), tag(0, 0), tag(1, 1), tag(2, 1), tag(0, 1)};
    e_grants = '{1, 2, 0, 1, 2, 0};
    n_grants = 6;
    n_checks++;
    if (busy_h[2] !== 1'b0) begin n_fail++; $display("FAIL early_idle_c2: got %b want 0", busy_h[2]); end
    n_checks++;
    if (gid_h[3] !== 2'd2) begin n_fail++; $display("FAIL early_next_grant_c3: got %0d want 2", gid_h[3]); end
`endif
    n_checks++;
    if (grant_log.size() !== n_grants) begin
      n_fail++;
      $display("FAIL early_grant_count: got %0d want %0d", grant_log.size(), n_grants);
    end else begin
      for (int g = 0; g < n_grants; g++) begin
        n_checks++;
        if (grant_log[g] !== e_grants[g]) begin n_fail++; $display("FAIL early_grant %0d: got %0d want %0d", g, grant_log[g], e_grants[g]); end
      end
    end
    n_checks++;
    if (beat_log.size() !== 6) begin
      n_fail++;
      $display("FAIL early_beat_count: got %0d want 6", beat_log.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        n_checks++;
        if (beat_log[j] !== e_beats[j]) begin n_fail++; $display("FAIL early_order beat%0d: got %h want %h", j, beat_log[j], e_beats[j]); end
      end
    end
  endtask

  task automatic test_reset_midburst();
    apply_reset();
    out_ack = 1'b0;
    for (int b = 0; b < 4; b++) src_q[3].push_back(tag(3, b));
    drive();
    tick();
    tick();
    tick();
    n_checks++;
    if (out_vld !== 1'b1) begin n_fail++; $display("FAIL rst_pre_out_vld: got %b want 1", out_vld); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_async_out_vld: got %b want 0", out_vld); end
    n_checks++;
    if (out_dout !== 32'h0) begin n_fail++; $display("FAIL rst_async_out_dout: got %h want 0", out_dout); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    n_checks++;
    if (req_ack !== 4'b0) begin n_fail++; $display("FAIL rst_async_req_ack: got %b want 0000", req_ack); end
    n_checks++;
    if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_async_grant_id: got %0d want 0", grant_id); end
    src_q[0].push_back(tag(0, 0));
    src_q[0].push_back(tag(0, 1));
    out_ack = 1'b1;
    drive();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    for (int c = 0; c < 10; c++) tick();
    n_checks++;
    if (grant_log.size() < 1) begin
      n_fail++;
      $display("FAIL rst_first_grant: got no grant want 0");
    end else if (grant_log[0] !== 0) begin
      n_fail++;
      $display("FAIL rst_first_grant: got %0d want 0", grant_log[0]);
    end
    n_checks++;
    if (beat_log.size() < 1) begin
      n_fail++;
      $display("FAIL rst_first_beat: got no beat want %h", tag(0, 0));
    end else if (beat_log[0] !== tag(0, 0)) begin
      n_fail++;
      $display("FAIL rst_first_beat: got %h want %h", beat_log[0], tag(0, 0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    prev_busy = 1'b0;
    reset_n   = 1'b0;
    out_ack   = 1'b1;
    req_vld   = '0;
    req_din   = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_early_release();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_leaf_out_arbiter
`default_nettype wire
